// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: occupancy state encoding and RISC-V NOP.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;

  // Encoding doubles as the occupancy count (number of valid entries).
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_state_e;

  // addi x0, x0, 0 -- the canonical RV32I NOP, used as the IF/ID bubble.
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

endpackage : pipe_pkg

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake and optional skid entry.
// Latency: 1 cycle from accept to out_valid/out_data; 1 beat/cycle throughput.
// Backpressure: SKID=1 -> registered in_ready (absorbs one extra beat);
//               SKID=0 -> in_ready = empty | out_ready (combinational).
//
// Ports:
//   clk        rising-edge clock for all state
//   reset      asynchronous, active-low reset
//   in_valid   upstream presents a beat        in_ready   stage accepts a beat
//   in_data    upstream payload (WIDTH)
//   out_valid  head entry is valid             out_ready  downstream takes head
//   out_data   head payload, or BUBBLE when empty
//   flush      discard all held entries and any beat presented this cycle
//   occupancy  number of valid entries (0..2)
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH  = 96,
  parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}},
  parameter bit               SKID   = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       occupancy
);

  occ_state_e       state_q, state_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             rdy_q;

  logic accept;
  logic deliver;
  logic load_main;
  logic load_skid;
  logic skid_to_main;

  // Next-state and data-steering decode.
  always_comb begin
    state_d      = state_q;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    accept       = in_valid & in_ready & ~flush;
    deliver      = (state_q != EMPTY) & out_ready;

    case (state_q)
      EMPTY: begin
        if (accept) begin
          load_main = 1'b1;
          state_d   = ONE;
        end
      end
      ONE: begin
        if (accept && deliver) begin
          load_main = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_d   = FULL;
        end else if (deliver) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only a drain can move the state.
        if (deliver) begin
          skid_to_main = 1'b1;
          state_d      = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Flush overrides everything; a head delivered this cycle still counts
    // as delivered because downstream sampled it.
    if (flush) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d != FULL);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_q <= BUBBLE;
      skid_q <= BUBBLE;
    end else begin
      if (load_main) begin
        main_q <= in_data;
      end else if (skid_to_main) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

  // Without a skid entry, ready must pass through combinationally so a full
  // single entry can still accept while its head is being taken.
  assign in_ready  = SKID ? rdy_q : ((state_q == EMPTY) | out_ready);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = out_valid ? main_q : BUBBLE;
  assign occupancy = state_q;

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// Directed + scoreboarded checks of pipe_stage_reg in skid and single-entry forms.
// Latency: n/a (testbench).
// Backpressure: driven directly by the stimulus sequence.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int unsigned      W     = 96;
  localparam logic [W-1:0]     BUB   = {64'd0, RV_NOP};
  localparam logic [W-1:0]     BUB0  = '0;

  logic         clk = 1'b0;
  logic         reset = 1'b1;

  // Skid instance (IF/ID configuration)
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         flush = 1'b0;
  logic [1:0]   occupancy;

  // Single-entry instance
  logic         s0_in_valid = 1'b0;
  logic         s0_in_ready;
  logic [W-1:0] s0_in_data = '0;
  logic         s0_out_valid;
  logic         s0_out_ready = 1'b0;
  logic [W-1:0] s0_out_data;
  logic         s0_flush = 1'b0;
  logic [1:0]   s0_occupancy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(W), .BUBBLE(BUB), .SKID(1'b1)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush(flush), .occupancy(occupancy)
  );

  pipe_stage_reg #(.WIDTH(W), .BUBBLE(BUB0), .SKID(1'b0)) dut0 (
    .clk(clk), .reset(reset),
    .in_valid(s0_in_valid), .in_ready(s0_in_ready), .in_data(s0_in_data),
    .out_valid(s0_out_valid), .out_ready(s0_out_ready), .out_data(s0_out_data),
    .flush(s0_flush), .occupancy(s0_occupancy)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks the skid instance's visible state.
  task automatic chk_state(input string tag, input int occ, input logic [W-1:0] dat,
                           input logic rdy);
    chk({tag, "_occ"}, W'(occupancy), W'(occ));
    chk({tag, "_vld"}, W'(out_valid), W'(occ != 0));
    chk({tag, "_dat"}, out_data, dat);
    chk({tag, "_rdy"}, W'(in_ready), W'(rdy));
  endtask

  logic [W-1:0] q[$];
  logic         exp_rdy;
  logic         m_acc;
  logic         m_del;
  logic [W-1:0] exp_dat;

  initial begin
    // ---------------- reset state, asserted before any clock edge
    #1 reset = 1'b0;
    #2;
    chk_state("rst", 0, BUB, 1'b1);
    chk("rst_s0_occ", W'(s0_occupancy), W'(0));
    chk("rst_s0_dat", s0_out_data, BUB0);
    step();
    step();
    reset = 1'b1;
    step();
    chk_state("post_rst", 0, BUB, 1'b1);

    // ---------------- stream: 0x1..0x8 back to back, out_ready=1
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = W'(i);
      step();
      chk_state($sformatf("stream%0d", i), 1, W'(i), 1'b1);
    end
    in_valid = 1'b0;
    step();
    chk_state("stream_end", 0, BUB, 1'b1);

    // ---------------- stall: 0xA, 0xB held, 0xC waits
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = W'(32'hA);
    step();
    chk_state("stall_a", 1, W'(32'hA), 1'b1);
    in_data = W'(32'hB);
    step();
    chk_state("stall_b", 2, W'(32'hA), 1'b0);
    in_data = W'(32'hC);
    step();
    chk_state("stall_c1", 2, W'(32'hA), 1'b0);
    step();
    chk_state("stall_c2", 2, W'(32'hA), 1'b0);
    out_ready = 1'b1;
    step();
    chk_state("drain_b", 1, W'(32'hB), 1'b1);
    step();
    chk_state("drain_c", 1, W'(32'hC), 1'b1);
    in_valid = 1'b0;
    step();
    chk_state("drain_end", 0, BUB, 1'b1);

    // ---------------- flush from FULL with 0xC presented
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = W'(32'hA);
    step();
    in_data = W'(32'hB);
    step();
    chk_state("fl_full", 2, W'(32'hA), 1'b0);
    in_data = W'(32'hC);
    flush   = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk_state("fl_after", 0, BUB, 1'b1);
    out_ready = 1'b1;
    step();
    chk_state("fl_noc1", 0, BUB, 1'b1);
    step();
    chk_state("fl_noc2", 0, BUB, 1'b1);

    // ---------------- asynchronous reset while FULL
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = W'(32'h7);
    step();
    in_data = W'(32'h8);
    step();
    in_valid = 1'b0;
    chk_state("ar_full", 2, W'(32'h7), 1'b0);
    #3 reset = 1'b0;
    #1;
    chk_state("ar_async", 0, BUB, 1'b1);
    step();
    reset = 1'b1;
    out_ready = 1'b1;
    step();
    chk_state("ar_noresid", 0, BUB, 1'b1);
    in_valid = 1'b1;
    in_data  = W'(32'h5);
    step();
    chk_state("ar_five", 1, W'(32'h5), 1'b1);
    in_valid = 1'b0;
    step();
    chk_state("ar_end", 0, BUB, 1'b1);

    // ---------------- single-entry instance
    s0_out_ready = 1'b0;
    s0_in_valid  = 1'b1;
    s0_in_data   = W'(32'h1);
    #1;
    chk("s0_rdy_empty", W'(s0_in_ready), W'(1));
    step();
    chk("s0_occ1", W'(s0_occupancy), W'(1));
    chk("s0_dat1", s0_out_data, W'(32'h1));
    chk("s0_rdy_held", W'(s0_in_ready), W'(0));
    s0_in_data = W'(32'h2);
    step();
    chk("s0_occ_nofull", W'(s0_occupancy), W'(1));
    chk("s0_dat_hold", s0_out_data, W'(32'h1));
    chk("s0_rdy_held2", W'(s0_in_ready), W'(0));
    s0_out_ready = 1'b1;
    #1;
    chk("s0_rdy_pass", W'(s0_in_ready), W'(1));
    step();
    chk("s0_occ_two", W'(s0_occupancy), W'(1));
    chk("s0_dat2", s0_out_data, W'(32'h2));
    s0_in_valid = 1'b0;
    step();
    chk("s0_occ_end", W'(s0_occupancy), W'(0));
    chk("s0_dat_end", s0_out_data, BUB0);

    // ---------------- random traffic against a queue scoreboard
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_data   = {32'hA5A5_0000, 32'd0, 32'(c)};
      #1;
      exp_rdy = (q.size() < 2);
      exp_dat = (q.size() != 0) ? q[0] : BUB;
      chk("rnd_occ", W'(occupancy), W'(q.size()));
      chk("rnd_vld", W'(out_valid), W'(q.size() != 0));
      chk("rnd_rdy", W'(in_ready), W'(exp_rdy));
      chk("rnd_dat", out_data, exp_dat);
      m_del = (q.size() != 0) && out_ready;
      m_acc = in_valid && exp_rdy && !flush;
      if (m_del) void'(q.pop_front());
      if (flush) q.delete();
      else if (m_acc) q.push_back(in_data);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    chk_state("rnd_end", 0, BUB, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_pipe_stage_reg

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 96, meaning payload width in bits (IF/ID use: pc_plus_4, pc, instruction).
REQ-002 The block SHALL have parameter BUBBLE, default {WIDTH{1'b0}}, meaning the value driven on out_data when no valid entry is present.
REQ-003 The block SHALL have parameter SKID, default 1, meaning 1 = two-entry skid buffer and 0 = single entry.
REQ-004 The block SHALL have port clk  input  1  meaning the single clock, all state changing on its rising edge.
REQ-005 The block SHALL have port reset  input  1  meaning asynchronous, active-low reset.
REQ-006 The block SHALL have port in_valid  input  1  meaning the upstream stage presents a beat.
REQ-007 The block SHALL have port in_ready  output  1  meaning the block accepts a beat this cycle.
REQ-008 The block SHALL have port in_data  input  WIDTH  meaning the upstream payload.
REQ-009 The block SHALL have port out_valid  output  1  meaning the head entry is valid.
REQ-010 The block SHALL have port out_ready  input  1  meaning downstream takes the head; low = stall.
REQ-011 The block SHALL have port out_data  output  WIDTH  meaning the head payload, or BUBBLE.
REQ-012 The block SHALL have port flush  input  1  meaning kill all held entries (branch or jump redirect).
REQ-013 The block SHALL have port occupancy  output  2  meaning the number of valid entries (0..2).

Function
REQ-014 A beat SHALL be accepted on a rising edge when in_valid and in_ready are both 1 and flush is 0; a beat SHALL be delivered when out_valid and out_ready are both 1.
REQ-015 Latency SHALL be 1 cycle: a beat accepted at edge N appears on out_data/out_valid after edge N.
REQ-016 Throughput SHALL be 1 beat per cycle while out_ready=1.
REQ-017 The state SHALL be one of EMPTY(0), ONE(1), FULL(2); occupancy SHALL equal the state encoding.
REQ-018 EMPTY: an accept SHALL load main and go to ONE; otherwise the state SHALL stay EMPTY.
REQ-019 ONE: accept+deliver SHALL load main and stay ONE; accept only SHALL load skid and go to FULL; deliver only SHALL go to EMPTY; neither SHALL hold.
REQ-020 FULL: deliver SHALL move skid into main and go to ONE; otherwise the state SHALL hold.
REQ-021 in_ready SHALL be a registered signal equal to (state != FULL) when SKID=1.
REQ-022 With SKID=0, in_ready SHALL equal (state == EMPTY) | out_ready (combinational pass-through of ready), and FULL SHALL be unreachable.
REQ-023 out_valid SHALL equal (state != EMPTY), and out_data SHALL equal main when valid and BUBBLE otherwise.
REQ-024 Data order SHALL be preserved: no beat is reordered, duplicated or lost except by flush.
REQ-025 When flush=1 at an edge, the next state SHALL be EMPTY regardless of the current state, and any beat presented that cycle SHALL be discarded.
REQ-026 A beat delivered in the flush cycle SHALL count as delivered, because downstream sampled it.
REQ-027 in_ready SHALL be 1 in the cycle after a flush.
REQ-028 A held entry SHALL keep its payload stable while out_ready=0.

Reset
REQ-029 When reset=0, the block SHALL asynchronously set state=EMPTY, out_valid=0, occupancy=0, out_data=BUBBLE, and in_ready=1.
REQ-030 Deassertion of reset SHALL take effect at the first rising edge of clk after reset goes high.
REQ-031 Reset mid-operation SHALL discard both entries and leave no residual beat.
REQ-032 The main and skid data registers SHALL reset to BUBBLE.

Structure
REQ-033 A shared package pipe_pkg SHALL hold the occupancy state enum (EMPTY/ONE/FULL) and the constant RV_NOP = 32'h0000_0013.
REQ-034 The IF/ID instance SHALL set BUBBLE to {64'd0, RV_NOP}.
REQ-035 The block SHALL contain no sub-module; the control FSM and the two data registers SHALL be flat in pipe_stage_reg.
REQ-036 The block SHALL contain no latches and no # delays; all sequential logic SHALL use clk with asynchronous reset only.

Verification
REQ-037 Stream test: with out_ready=1, send beats 0x1..0x8 back to back -> out_data shows 0x1..0x8 on consecutive cycles starting 1 cycle later, and occupancy stays 1.
REQ-038 Stall test: hold out_ready=0 and send 0xA, 0xB, 0xC -> 0xA and 0xB are held, in_ready falls after 0xB, 0xC waits; release out_ready -> 0xA, 0xB, 0xC are delivered in order.
REQ-039 Flush test: in FULL (0xA/0xB) with in_valid=1, data 0xC, assert flush for 1 cycle -> next cycle occupancy=0, out_data=BUBBLE, in_ready=1, and 0xC is never delivered.
REQ-040 Reset test: drop reset asynchronously mid-clock while FULL -> out_valid=0 immediately, without waiting for a clock edge; release reset and send 0x5 -> 0x5 is delivered after 1 cycle.
REQ-041 SKID=0 test: hold out_ready=0 and send 0x1, 0x2 -> in_ready=0 while 0x1 is held, occupancy never reaches 2.
REQ-042 Random test: random in_valid/out_ready/flush for 10k cycles against a scoreboard -> no loss, duplication or reordering except beats cleared by flush.
